// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports, the shared response bus and the memory
// strobe bus of dmem_arbiter; slave is the arbiter side, master the environment.
interface dmem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;

  logic [31:0] rdata;
  logic        err;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
    output rdata, err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
    input  rdata, err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE (grant) -> ACCESS (memory) -> RESP (rvalid).
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration (default fixed priority, m0 wins).
// Handshake: a requester holds req and its command until it sees gnt high in the same cycle;
// gnt and rvalid are single-cycle pulses, and rdata/err are meaningful only while rvalid is high.
module dmem_arbiter #(
  parameter int MEM_BYTES = 10240
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_arbiter_if.slave    bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_t      state_q, state_d;
  logic        lat_we, lat_id;
  logic [31:0] lat_addr, lat_wdata, rdata_q;
  logic        gnt0, gnt1, oor;

  // Unsigned compare on the full address, so addresses near 2^32 never wrap into range.
  assign oor       = lat_addr > LAST_WORD;
  assign dbg_state = state_q;

`ifdef DMEM_ARB_RR_EN
  logic rr_last;  // requester granted most recently; reset value 1 favours m0

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && rst_n) begin
      if (bus.m0_req && bus.m1_req) begin
        gnt0 = rr_last;
        gnt1 = !rr_last;
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (gnt0 || gnt1) begin
      rr_last <= gnt1;
    end
  end
`else
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && rst_n) begin
      gnt0 = bus.m0_req;
      gnt1 = bus.m1_req && !bus.m0_req;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt0 || gnt1) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_we    <= 1'b0;
      lat_id    <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      if (gnt0) begin
        lat_we    <= bus.m0_we;
        lat_addr  <= bus.m0_addr;
        lat_wdata <= bus.m0_wdata;
        lat_id    <= 1'b0;
      end else if (gnt1) begin
        lat_we    <= bus.m1_we;
        lat_addr  <= bus.m1_addr;
        lat_wdata <= bus.m1_wdata;
        lat_id    <= 1'b1;
      end
      if (state_q == ACCESS) begin
        rdata_q <= (!lat_we && !oor) ? bus.mem_rdata : 32'h0;
      end
    end
  end

  // mem_write is decoded from the asynchronously reset state, so it drops as soon as rst_n falls.
  always_comb begin
    bus.m0_gnt    = gnt0;
    bus.m1_gnt    = gnt1;
    bus.m0_rvalid = 1'b0;
    bus.m1_rvalid = 1'b0;
    bus.rdata     = 32'h0;
    bus.err       = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    case (state_q)
      ACCESS: begin
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
        bus.mem_write = lat_we && !oor;
        bus.mem_read  = !lat_we && !oor;
      end
      RESP: begin
        bus.m0_rvalid = !lat_id;
        bus.m1_rvalid = lat_id;
        bus.rdata     = rdata_q;
        bus.err       = oor;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int          MEM_BYTES = 10240;
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- memory behind the arbiter ----------------
  logic [7:0] phys_mem [MEM_BYTES];
  logic [7:0] ref_mem  [MEM_BYTES];
  logic       mem_clear;
  int         rd_idx;

  always_comb begin
    rd_idx        = int'(bus.mem_addr);
    bus.mem_rdata = 32'hA5A5_A5A5;
    if (bus.mem_addr <= LAST_WORD)
      bus.mem_rdata = {phys_mem[rd_idx], phys_mem[rd_idx+1], phys_mem[rd_idx+2], phys_mem[rd_idx+3]};
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MEM_BYTES; i++) phys_mem[i] <= 8'h00;
    end else if (bus.mem_write && rst_n && bus.mem_addr <= LAST_WORD) begin
      phys_mem[int'(bus.mem_addr)]     <= bus.mem_wdata[31:24];
      phys_mem[int'(bus.mem_addr) + 1] <= bus.mem_wdata[23:16];
      phys_mem[int'(bus.mem_addr) + 2] <= bus.mem_wdata[15:8];
      phys_mem[int'(bus.mem_addr) + 3] <= bus.mem_wdata[7:0];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];

  bit          t_valid;
  bit          t_id, t_we;
  logic [31:0] t_addr, t_wdata;
  int          t_g;
  bit          last_id;

  bit          s_g0, s_g1, s_rv0, s_rv1, s_rd, s_wr, s_err;
  logic [31:0] s_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int i;
    i = int'(a);
    return {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
    int i;
    i = int'(a);
    ref_mem[i]   = d[31:24];
    ref_mem[i+1] = d[23:16];
    ref_mem[i+2] = d[15:8];
    ref_mem[i+3] = d[7:0];
  endtask

  task automatic model_reset();
    t_valid = 1'b0;
    last_id = 1'b1;
    exp_q.delete();
  endtask

  // One cycle of the contract: a grant at cycle g means memory access at g+1 and rvalid at g+2.
  task automatic check_cycle();
    bit          e_g0 = 0, e_g1 = 0, e_rd = 0, e_wr = 0, e_rv0 = 0, e_rv1 = 0, e_err = 0, done = 0;
    logic [31:0] e_maddr = 0, e_mwd = 0, e_rdata = 0;
    bit          t_oor;
    t_oor = t_addr > LAST_WORD;
    if (t_valid && cyc == t_g + 1) begin
      e_maddr = t_addr;
      e_mwd   = t_wdata;
      e_wr    = t_we && !t_oor;
      e_rd    = !t_we && !t_oor;
      exp_q.push_back((t_we || t_oor) ? 32'h0 : ref_word(t_addr));
    end else if (t_valid && cyc == t_g + 2) begin
      e_rv0 = !t_id;
      e_rv1 = t_id;
      e_err = t_oor;
      if (exp_q.size() > 0) e_rdata = exp_q.pop_front();
      if (t_we && !t_oor) ref_write(t_addr, t_wdata);
      done = 1;
    end
    if (!t_valid) begin
      if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_RR_EN
        e_g0 = last_id;
        e_g1 = !last_id;
`else
        e_g0 = 1;
`endif
      end else begin
        e_g0 = bus.m0_req;
        e_g1 = bus.m1_req;
      end
      if (e_g0 || e_g1) begin
        t_valid = 1;
        t_id    = e_g1;
        t_we    = e_g1 ? bus.m1_we    : bus.m0_we;
        t_addr  = e_g1 ? bus.m1_addr  : bus.m0_addr;
        t_wdata = e_g1 ? bus.m1_wdata : bus.m0_wdata;
        t_g     = cyc;
        last_id = e_g1;
      end
    end
    if (done) t_valid = 0;
    chk("m0_gnt", bus.m0_gnt, e_g0);
    chk("m1_gnt", bus.m1_gnt, e_g1);
    chk("mem_read", bus.mem_read, e_rd);
    chk("mem_write", bus.mem_write, e_wr);
    chk("mem_addr", bus.mem_addr, e_maddr);
    chk("mem_wdata", bus.mem_wdata, e_mwd);
    chk("m0_rvalid", bus.m0_rvalid, e_rv0);
    chk("m1_rvalid", bus.m1_rvalid, e_rv1);
    chk("err", bus.err, e_err);
    chk("rdata", bus.rdata, e_rdata);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    s_g0 = bus.m0_gnt;   s_g1 = bus.m1_gnt;
    s_rv0 = bus.m0_rvalid; s_rv1 = bus.m1_rvalid;
    s_rd = bus.mem_read; s_wr = bus.mem_write;
    s_err = bus.err;     s_rdata = bus.rdata;
    check_cycle();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " m0_gnt"}, bus.m0_gnt, 0);
    chk({tag, " m1_gnt"}, bus.m1_gnt, 0);
    chk({tag, " m0_rvalid"}, bus.m0_rvalid, 0);
    chk({tag, " m1_rvalid"}, bus.m1_rvalid, 0);
    chk({tag, " rdata"}, bus.rdata, 0);
    chk({tag, " err"}, bus.err, 0);
    chk({tag, " mem_read"}, bus.mem_read, 0);
    chk({tag, " mem_write"}, bus.mem_write, 0);
    chk({tag, " mem_addr"}, bus.mem_addr, 0);
    chk({tag, " mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, " state"}, 32'(dbg_state), 0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero({tag, " early"});
    repeat (2) @(posedge clk);
    #1;
    chk_zero({tag, " held"});
    rst_n = 1'b1;
  endtask

  task automatic drive(input bit id, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (!id) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wd;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wd;
    end
  endtask

  task automatic wait_gnt(input bit id, input string tag, output bit got);
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      step();
      if (id ? s_g1 : s_g0) got = 1;
    end
    chk({tag, " gnt seen"}, 32'(got), 1);
  endtask

  typedef struct {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic do_vec(input vec_t v, input int idx);
    bit    got;
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive(v.id, 1'b1, v.we, v.addr, v.wdata);
    wait_gnt(v.id, tag, got);
    drive(v.id, 1'b0, 1'b0, 32'h0, 32'h0);
    if (got) begin
      step();
      chk({tag, " access mem_write"}, 32'(s_wr), 32'(v.we && !v.exp_err));
      chk({tag, " access mem_read"}, 32'(s_rd), 32'(!v.we && !v.exp_err));
      step();
      chk({tag, " resp rvalid"}, 32'(v.id ? s_rv1 : s_rv0), 1);
      chk({tag, " resp other rvalid"}, 32'(v.id ? s_rv0 : s_rv1), 0);
      chk({tag, " resp rdata"}, s_rdata, v.exp_rdata);
      chk({tag, " resp err"}, 32'(s_err), 32'(v.exp_err));
    end
  endtask

  task automatic rand_cmd(output logic req, output logic we, output logic [31:0] addr,
                          output logic [31:0] wd);
    req = ($urandom_range(0, 2) != 0);
    we  = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       addr = LAST_WORD - 32'd4 + 32'($urandom_range(0, 8));
      1:       addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      default: addr = 32'($urandom_range(0, 47));
    endcase
    wd = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit          got;
    int          order[$];
    int          exp_order [4];
    logic        r, w;
    logic [31:0] a, d;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_clear = 1'b1;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    mem_clear = 1'b0;
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    vecs[0] = '{1'b0, 1'b1, 32'h10,        32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h10,        32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h14,        32'h01234567, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h12,        32'h0,        1'b0, 32'hBEEF0123};
    vecs[4] = '{1'b1, 1'b0, 32'd10237,     32'h0,        1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 32'd10236,     32'hCAFEF00D, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'd10236,     32'h0,        1'b0, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 32'h55555555, 1'b1, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 32'd10240,     32'h0,        1'b1, 32'h0};
    vecs[9] = '{1'b1, 1'b0, 32'h40,        32'h0,        1'b0, 32'h0};

    for (int i = 0; i < 9; i++) do_vec(vecs[i], i);
    step();

    // Reset in the middle of an m1 store's ACCESS cycle.
    drive(1'b1, 1'b1, 1'b1, 32'h40, 32'h11223344);
    wait_gnt(1'b1, "abort", got);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    chk("abort mem_write before reset", 32'(bus.mem_write), 1);
    rst_n = 1'b0;
    #1;
    chk("abort mem_write async drop", 32'(bus.mem_write), 0);
    apply_reset("abort");
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort no m1_rvalid", 32'(s_rv1), 0);
    end
    chk("abort state idle", 32'(dbg_state), 0);
    do_vec(vecs[9], 9);
    step();

    // m1 request raised during m0's ACCESS waits until after m0's rvalid.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    wait_gnt(1'b0, "late", got);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
    step();
    chk("late m1 no gnt in access", 32'(s_g1), 0);
    step();
    chk("late m0 rvalid", 32'(s_rv0), 1);
    chk("late m1 no gnt in resp", 32'(s_g1), 0);
    step();
    chk("late m1 gnt next idle", 32'(s_g1), 1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) step();

    // Both requesters loading continuously from reset.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
    apply_reset("tie");
`ifdef DMEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < 30 && order.size() < 4; k++) begin
      step();
      if (s_g0) order.push_back(0);
      if (s_g1) order.push_back(1);
    end
    chk("tie grant count", 32'(order.size()), 4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk($sformatf("tie grant %0d id", i), 32'(order[i]), 32'(exp_order[i]));
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) step();

    // Randomized traffic, each requester holding its command until granted.
    for (int k = 0; k < 900; k++) begin
      step();
      if (s_g0 || !bus.m0_req) begin
        rand_cmd(r, w, a, d);
        drive(1'b0, r, w, a, d);
      end
      if (s_g1 || !bus.m1_req) begin
        rand_cmd(r, w, a, d);
        drive(1'b1, r, w, a, d);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
